// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ack;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          cpu_stall;
  logic [1:0]    curr_gnt;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output cpu_stall, curr_gnt
  );

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  cpu_stall, curr_gnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (CPU/DMA) single-port memory arbiter; MEMARB_ROUND_ROBIN_EN selects round-robin ties
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          win_dma_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;

  logic          pick_dma;
  logic          grant;
  logic          last_busy;
  logic          cpu_ack_c;
  logic          dma_ack_c;

  assign grant     = (state_q == S_IDLE) && (bus.cpu_req || bus.dma_req);
  assign last_busy = (state_q == S_BUSY) && (cnt_q <= 4'd1);

`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_dma_q;

  // Remember who took the most recent grant so the next tie goes the other way
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dma_q <= 1'b1;
    end else if (grant) begin
      last_dma_q <= pick_dma;
    end
  end
`endif

  // Choose the requester for the next grant; only consumed while idle
  always_comb begin
    pick_dma = 1'b0;
    if (bus.dma_req && !bus.cpu_req) begin
      pick_dma = 1'b1;
    end else if (bus.dma_req && bus.cpu_req) begin
`ifdef MEMARB_ROUND_ROBIN_EN
      pick_dma = ~last_dma_q;
`else
      pick_dma = 1'b0;
`endif
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> BUSY on any request, BUSY for LAT cycles, one ACK cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.cpu_req || bus.dma_req) state_d = S_BUSY;
      S_BUSY:  if (cnt_q <= 4'd1) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes only in BUSY, ack only in ACK, bus fields from latched copies
  always_comb begin
    cpu_ack_c     = (state_q == S_ACK) && !win_dma_q;
    dma_ack_c     = (state_q == S_ACK) &&  win_dma_q;
    bus.mem_read  = (state_q == S_BUSY) && !we_q;
    bus.mem_write = (state_q == S_BUSY) &&  we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.cpu_ack   = cpu_ack_c;
    bus.dma_ack   = dma_ack_c;
    bus.cpu_rdata = cpu_rdata_q;
    bus.dma_rdata = dma_rdata_q;
    bus.cpu_stall = bus.cpu_req && !cpu_ack_c;
    bus.curr_gnt  = 2'b00;
    if (state_q != S_IDLE) begin
      bus.curr_gnt = win_dma_q ? 2'b10 : 2'b01;
    end
  end

  // Latch the winner's attributes at grant, count BUSY cycles, capture read data on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      win_dma_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (grant) begin
        cnt_q     <= LAT_CNT;
        win_dma_q <= pick_dma;
        we_q      <= pick_dma ? bus.dma_we    : bus.cpu_we;
        addr_q    <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
        wdata_q   <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (last_busy && !we_q) begin
        if (win_dma_q) begin
          dma_rdata_q <= bus.mem_rdata;
        end else begin
          cpu_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

endmodule
